// File: rtl/spi_slave_char_engine_if.sv
// Pin-level SPI bus plus the rx/tx character streams of the SPI slave character engine.
// The slave modport is the engine side; the master modport is the system/VIP side.
interface spi_slave_char_engine_if #(
  parameter int CHAR_LENGTH = 8
);
  logic                   sclk_i;
  logic                   cs_n_i;
  logic                   mosi_i;
  logic                   miso_o;
  logic                   miso_oe_o;
  logic [CHAR_LENGTH-1:0] rx_data_o;
  logic                   rx_valid_o;
  logic                   rx_ready_i;
  logic [CHAR_LENGTH-1:0] tx_data_i;
  logic                   tx_valid_i;
  logic                   tx_ready_o;

  modport slave (
    input  sclk_i, cs_n_i, mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
    output miso_o, miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o
  );

  modport master (
    output sclk_i, cs_n_i, mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
    input  miso_o, miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o
  );
endinterface

// File: rtl/spi_slave_char_engine.sv
// SPI slave character engine: oversamples the SPI bus in the pclk domain, assembles
// mosi characters into an rx FIFO and serialises tx FIFO characters onto miso.
module spi_slave_char_engine #(
  parameter int CHAR_LENGTH  = 8,
  parameter int MAXIMUM_BITS = 1024,
  parameter int RX_DEPTH     = 4,
  parameter int TX_DEPTH     = 2
) (
  input  logic                                pclk,
  input  logic                                preset_n,
  input  logic                                cfg_cpol,
  input  logic                                cfg_cpha,
  input  logic                                cfg_msb_first,
  spi_slave_char_engine_if.slave              bus,
  output logic                                frame_active_o,
  output logic                                frame_done_o,
  output logic [$clog2(MAXIMUM_BITS+1)-1:0]   frame_bits_o,
  output logic                                overrun_o,
  output logic                                underrun_o
);
  localparam int BIW = $clog2(CHAR_LENGTH+1);
  localparam int FBW = $clog2(MAXIMUM_BITS+1);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(CHAR_LENGTH-1);
  localparam logic [BIW-1:0] FULL_CNT = BIW'(CHAR_LENGTH);
  localparam logic [BIW-1:0] BIT_ONE  = 1;
  localparam logic [FBW-1:0] MAX_BITS = FBW'(MAXIMUM_BITS);
  localparam logic [FBW-1:0] FB_ONE   = 1;
  localparam logic [RAW:0]   RX_FULL  = (RAW+1)'(RX_DEPTH);
  localparam logic [RAW:0]   RX_ONE   = 1;
  localparam logic [RAW-1:0] RP_ONE   = 1;
  localparam logic [TAW:0]   TX_FULL  = (TAW+1)'(TX_DEPTH);
  localparam logic [TAW:0]   TX_ONE   = 1;
  localparam logic [TAW-1:0] TP_ONE   = 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_q, cs_q;
  logic       cpol_q, cpha_q, msb_q;
  logic [BIW-1:0] bit_idx, tx_cnt;
  logic [CHAR_LENGTH-1:0] rx_shift, tx_shift, rx_push_data;
  logic       rx_push;

  logic [CHAR_LENGTH-1:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [RAW:0]   rx_count;
  logic [CHAR_LENGTH-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [TAW:0]   tx_count;

  // The cs_n chain resets to "selected" so a reset landing mid-frame never sees a
  // falling edge; the engine waits for cs_n to go high and fall again.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.sclk_i};
      cs_sync   <= {cs_sync[0], bus.cs_n_i};
      mosi_sync <= {mosi_sync[0], bus.mosi_i};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, lead_edge, trail_edge;
  logic sample_edge, shift_edge, start_load, reload, tx_empty, tx_pop, tx_push;
  logic rx_pop, rx_wr_en, load_msb, load_bit, next_bit;
  logic [CHAR_LENGTH-1:0] rx_next, load_val, load_rest, next_rest;

  assign sclk_rise   = sclk_sync[1] & ~sclk_q;
  assign sclk_fall   = ~sclk_sync[1] & sclk_q;
  assign cs_fall     = ~cs_sync[1] & cs_q;
  assign cs_rise     = cs_sync[1] & ~cs_q;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = (state == ACTIVE) & (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = (state == ACTIVE) & ~cs_rise & (cpha_q ? lead_edge : trail_edge);

  assign rx_next = msb_q ? {rx_shift[CHAR_LENGTH-2:0], mosi_sync[1]}
                         : {mosi_sync[1], rx_shift[CHAR_LENGTH-1:1]};

  // Frame start uses the live cfg bits because they are only latched in that cycle.
  assign tx_empty   = (tx_count == '0);
  assign start_load = (state == IDLE) & cs_fall;
  assign reload     = shift_edge & (tx_cnt == FULL_CNT);
  assign tx_pop     = (start_load | reload) & ~tx_empty;
  assign load_msb   = (state == IDLE) ? cfg_msb_first : msb_q;
  assign load_val   = tx_empty ? '0 : tx_mem[tx_rd];
  assign load_bit   = load_msb ? load_val[CHAR_LENGTH-1] : load_val[0];
  assign load_rest  = load_msb ? (load_val << 1) : (load_val >> 1);
  assign next_bit   = msb_q ? tx_shift[CHAR_LENGTH-1] : tx_shift[0];
  assign next_rest  = msb_q ? (tx_shift << 1) : (tx_shift >> 1);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state          <= IDLE;
      cpol_q         <= 1'b0;
      cpha_q         <= 1'b0;
      msb_q          <= 1'b0;
      bit_idx        <= '0;
      tx_cnt         <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      rx_push        <= 1'b0;
      rx_push_data   <= '0;
      bus.miso_o     <= 1'b0;
      bus.miso_oe_o  <= 1'b0;
      frame_active_o <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_bits_o   <= '0;
      underrun_o     <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
      rx_push      <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state          <= ACTIVE;
            frame_active_o <= 1'b1;
            bus.miso_oe_o  <= 1'b1;
            cpol_q         <= cfg_cpol;
            cpha_q         <= cfg_cpha;
            msb_q          <= cfg_msb_first;
            bit_idx        <= '0;
            frame_bits_o   <= '0;
            underrun_o     <= tx_empty;
            if (!cfg_cpha) begin
              bus.miso_o <= load_bit;
              tx_shift   <= load_rest;
              tx_cnt     <= BIT_ONE;
            end else begin
              tx_shift <= load_val;
              tx_cnt   <= '0;
            end
          end
        end
        ACTIVE: begin
          if (sample_edge) begin
            rx_shift <= rx_next;
            if (frame_bits_o != MAX_BITS) frame_bits_o <= frame_bits_o + FB_ONE;
            if (bit_idx == LAST_IDX) begin
              bit_idx      <= '0;
              rx_push      <= 1'b1;
              rx_push_data <= rx_next;
            end else begin
              bit_idx <= bit_idx + BIT_ONE;
            end
          end
          if (shift_edge) begin
            if (reload) begin
              underrun_o <= tx_empty;
              bus.miso_o <= load_bit;
              tx_shift   <= load_rest;
              tx_cnt     <= BIT_ONE;
            end else begin
              bus.miso_o <= next_bit;
              tx_shift   <= next_rest;
              tx_cnt     <= tx_cnt + BIT_ONE;
            end
          end
          if (cs_rise) begin
            state          <= DONE;
            frame_active_o <= 1'b0;
            frame_done_o   <= 1'b1;
            bus.miso_oe_o  <= 1'b0;
            bus.miso_o     <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign rx_pop   = bus.rx_valid_o & bus.rx_ready_i;
  assign rx_wr_en = rx_push & ((rx_count != RX_FULL) | rx_pop);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      rx_wr     <= '0;
      rx_rd     <= '0;
      rx_count  <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= rx_push & ~rx_wr_en;
      if (rx_wr_en) rx_wr <= rx_wr + RP_ONE;
      if (rx_pop)   rx_rd <= rx_rd + RP_ONE;
      if (rx_wr_en & ~rx_pop)      rx_count <= rx_count + RX_ONE;
      else if (~rx_wr_en & rx_pop) rx_count <= rx_count - RX_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (rx_wr_en) rx_mem[rx_wr] <= rx_push_data;
  end

  assign bus.rx_valid_o = (rx_count != '0);
  assign bus.rx_data_o  = bus.rx_valid_o ? rx_mem[rx_rd] : '0;

  assign bus.tx_ready_o = (tx_count != TX_FULL) | tx_pop;
  assign tx_push        = bus.tx_valid_i & bus.tx_ready_o;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TP_ONE;
      if (tx_pop)  tx_rd <= tx_rd + TP_ONE;
      if (tx_push & ~tx_pop)      tx_count <= tx_count + TX_ONE;
      else if (~tx_push & tx_pop) tx_count <= tx_count - TX_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_data_i;
  end
endmodule

// File: tb/tb_spi_slave_char_engine.sv
// Bench for spi_slave_char_engine: drives SPI frames as a master at pclk = 8x sclk and
// compares miso, rx stream and status pulses against a character-level model.
module tb_spi_slave_char_engine;
  localparam int HALF = 4;

  logic pclk, preset_n, cfg_cpol, cfg_cpha, cfg_msb_first;
  logic frame_active_o, frame_done_o, overrun_o, underrun_o;
  logic [10:0] frame_bits_o;

  spi_slave_char_engine_if #(.CHAR_LENGTH(8)) bus ();

  spi_slave_char_engine #(
    .CHAR_LENGTH(8), .MAXIMUM_BITS(1024), .RX_DEPTH(4), .TX_DEPTH(2)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_msb_first(cfg_msb_first),
    .bus(bus),
    .frame_active_o(frame_active_o), .frame_done_o(frame_done_o),
    .frame_bits_o(frame_bits_o), .overrun_o(overrun_o), .underrun_o(underrun_o)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int checks = 0;
  int passes = 0;
  int ovr_cnt = 0, und_cnt = 0, done_cnt = 0;
  logic [7:0] got_rx [$];
  int rx_rd = 0;
  logic [7:0] exp_rx [$];
  logic [7:0] tx_model [$];
  bit mosi_bits [64];
  logic [63:0] miso_got;
  int done_snap, rx_snap;

  // Counts status pulses and records every accepted rx character.
  always @(negedge pclk) begin
    if (bus.rx_valid_o && bus.rx_ready_i) got_rx.push_back(bus.rx_data_o);
    if (overrun_o)    ovr_cnt++;
    if (underrun_o)   und_cnt++;
    if (frame_done_o) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput(tag, {bus.miso_o, bus.miso_oe_o, bus.rx_valid_o, bus.tx_ready_o,
                      frame_active_o, frame_done_o, frame_bits_o, overrun_o, underrun_o,
                      bus.rx_data_o},
                {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic pushTx(input logic [7:0] ch);
    logic rdy;
    @(posedge pclk); #1;
    bus.tx_data_i  = ch;
    bus.tx_valid_i = 1'b1;
    @(negedge pclk);
    rdy = bus.tx_ready_o;
    @(posedge pclk); #1;
    bus.tx_valid_i = 1'b0;
    if (rdy) tx_model.push_back(ch);
  endtask

  task automatic setMosiChar(input int idx, input logic [7:0] val, input bit msb);
    for (int b = 0; b < 8; b++) mosi_bits[idx*8+b] = msb ? val[7-b] : val[b];
  endtask

  task automatic randomMosi(input int nbits);
    for (int k = 0; k < nbits; k++) mosi_bits[k] = 1'($urandom_range(0, 1));
  endtask

  // SPI master: one frame of nbits, capturing miso at each master sample point.
  task automatic applyStimulus(input bit cpol, input bit cpha, input bit msb, input int nbits);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_msb_first = msb;
    bus.sclk_i = cpol;
    bus.mosi_i = 1'b0;
    miso_got = '0;
    repeat (4) @(negedge pclk);
    bus.cs_n_i = 1'b0;
    if (!cpha) bus.mosi_i = mosi_bits[0];
    repeat (HALF) @(negedge pclk);
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        miso_got[k] = bus.miso_o;
        bus.sclk_i = ~cpol;
        repeat (HALF) @(negedge pclk);
        bus.sclk_i = cpol;
        if (k + 1 < nbits) bus.mosi_i = mosi_bits[k+1];
        repeat (HALF) @(negedge pclk);
      end else begin
        bus.sclk_i = ~cpol;
        bus.mosi_i = mosi_bits[k];
        repeat (HALF) @(negedge pclk);
        miso_got[k] = bus.miso_o;
        bus.sclk_i = cpol;
        repeat (HALF) @(negedge pclk);
      end
    end
    bus.cs_n_i = 1'b1;
    repeat (10) @(negedge pclk);
  endtask

  task automatic checkRx();
    checkOutput("rx_char_count", 64'(got_rx.size() - rx_rd), 64'(exp_rx.size()));
    while (exp_rx.size() > 0 && rx_rd < got_rx.size()) begin
      checkOutput("rx_char", got_rx[rx_rd], exp_rx.pop_front());
      rx_rd++;
    end
    exp_rx.delete();
    rx_rd = got_rx.size();
  endtask

  // Model: each frame loads one character at start plus one per completed character
  // boundary crossed by a shift edge; an empty queue yields 0x00 and an underrun.
  task automatic runFrame(input bit cpol, input bit cpha, input bit msb, input int nbits,
                          input bit hold);
    int loads, exp_und, exp_ovr, und0, ovr0, done0;
    logic [7:0] ch, val;
    logic [63:0] exp_miso;
    loads    = cpha ? 1 + (nbits - 1) / 8 : 1 + nbits / 8;
    exp_und  = 0;
    exp_ovr  = 0;
    exp_miso = '0;
    for (int i = 0; i < loads; i++) begin
      if (tx_model.size() > 0) ch = tx_model.pop_front();
      else begin
        ch = 8'h00;
        exp_und++;
      end
      for (int b = 0; b < 8; b++)
        if (i*8 + b < nbits) exp_miso[i*8+b] = msb ? ch[7-b] : ch[b];
    end
    for (int c = 0; c < nbits / 8; c++) begin
      val = '0;
      for (int b = 0; b < 8; b++)
        if (mosi_bits[c*8+b]) val = val | (8'h01 << (msb ? 7 - b : b));
      if (!hold || c < 4) exp_rx.push_back(val);
      else exp_ovr++;
    end
    und0 = und_cnt; ovr0 = ovr_cnt; done0 = done_cnt;
    applyStimulus(cpol, cpha, msb, nbits);
    checkOutput("frame_bits", 64'(frame_bits_o), 64'(nbits));
    checkOutput("frame_done_pulses", 64'(done_cnt - done0), 64'd1);
    checkOutput("underrun_pulses", 64'(und_cnt - und0), 64'(exp_und));
    checkOutput("overrun_pulses", 64'(ovr_cnt - ovr0), 64'(exp_ovr));
    checkOutput("miso_bits", miso_got, exp_miso);
    checkOutput("idle_active_oe", {62'd0, frame_active_o, bus.miso_oe_o}, 64'd0);
    if (!hold) checkRx();
  endtask

  initial begin
    preset_n = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_msb_first = 1'b1;
    bus.sclk_i = 1'b0; bus.cs_n_i = 1'b1; bus.mosi_i = 1'b0;
    bus.rx_ready_i = 1'b1; bus.tx_data_i = '0; bus.tx_valid_i = 1'b0;
    repeat (3) @(negedge pclk);
    checkResetValues("reset_values");
    preset_n = 1'b1;
    repeat (4) @(negedge pclk);
    checkResetValues("post_reset_idle");

    // Mode 0, MSB first, two characters, empty tx FIFO.
    setMosiChar(0, 8'hA5, 1'b1);
    setMosiChar(1, 8'h3C, 1'b1);
    runFrame(1'b0, 1'b0, 1'b1, 16, 1'b0);

    // Mode 3, LSB first, preloaded tx characters.
    pushTx(8'h81);
    pushTx(8'h7E);
    randomMosi(16);
    runFrame(1'b1, 1'b1, 1'b0, 16, 1'b0);

    // Consumer stalled: five characters, the fifth is dropped.
    @(negedge pclk);
    bus.rx_ready_i = 1'b0;
    randomMosi(40);
    runFrame(1'b0, 1'b0, 1'b1, 40, 1'b1);
    checkOutput("rx_held_valid", 64'(bus.rx_valid_o), 64'd1);
    checkOutput("rx_held_data", 64'(bus.rx_data_o), 64'(exp_rx[0]));
    repeat (20) @(negedge pclk);
    checkOutput("rx_held_data_stable", 64'(bus.rx_data_o), 64'(exp_rx[0]));
    bus.rx_ready_i = 1'b1;
    for (int i = 0; i < 60 && (got_rx.size() - rx_rd) < 4; i++) @(negedge pclk);
    checkRx();

    // Mode 1, empty tx FIFO, one character.
    randomMosi(8);
    runFrame(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8, 1'b0);

    // Mode 2, frame cut after 13 bits.
    pushTx(8'($urandom));
    randomMosi(13);
    runFrame(1'b1, 1'b0, 1'b1, 13, 1'b0);

    // Reset in the middle of the first character of a frame.
    pushTx(8'h11);
    pushTx(8'h22);
    randomMosi(16);
    fork
      applyStimulus(1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (52) @(negedge pclk);
        preset_n = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        done_snap = done_cnt;
        rx_snap   = got_rx.size();
        checkResetValues("mid_frame_reset");
        @(negedge pclk);
        checkResetValues("mid_frame_reset_next");
      end
    join
    checkOutput("no_done_after_reset", 64'(done_cnt - done_snap), 64'd0);
    checkOutput("no_rx_after_reset", 64'(got_rx.size() - rx_snap), 64'd0);
    checkOutput("frame_bits_after_reset", 64'(frame_bits_o), 64'd0);
    tx_model.delete();
    exp_rx.delete();
    rx_rd = got_rx.size();
    setMosiChar(0, 8'h5A, 1'b1);
    runFrame(1'b0, 1'b0, 1'b1, 8, 1'b0);

    // Randomised frames: mode, bit order, length and tx preload.
    for (int f = 0; f < 8; f++) begin
      int npre, nbits;
      npre  = $urandom_range(0, 2);
      nbits = $urandom_range(1, 40);
      for (int p = 0; p < npre; p++) pushTx(8'($urandom));
      randomMosi(nbits);
      runFrame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), nbits, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
